program_mem_arbiter: RTL
========================

# program_mem_arbiter

- **Function:** arbitrates the single external program-memory read port among `NUM_CONSUMERS` instruction fetch units using a round-robin policy.
- **Handshakes:** each consumer port speaks the fetch unit's valid/ready protocol. The memory side uses the same protocol.
- **Position:** sits directly upstream of the per-core fetch units and directly downstream of program memory.
- **Concurrency:** exactly one memory read is outstanding at a time.

## Interface

Parameters:
- `NUM_CONSUMERS`, default 4: number of fetch units served; 1 is legal.
- `ADDR_BITS`, default 8: program memory address width.
- `DATA_BITS`, default 16: instruction width.

Ports:
- `clk`  in  1: single clock; all logic on rising edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `consumer_read_valid`  in  [NUM_CONSUMERS]: per-consumer read request.
- `consumer_read_address`  in  [NUM_CONSUMERS][ADDR_BITS]: per-consumer address; held while valid.
- `consumer_read_ready`  out  [NUM_CONSUMERS]: one-cycle response pulse.
- `consumer_read_data`  out  [NUM_CONSUMERS][DATA_BITS]: response data; held until the next response to that consumer.
- `mem_read_valid`  out  1: request to program memory.
- `mem_read_address`  out  ADDR_BITS: memory address.
- `mem_read_ready`  in  1: memory response strobe.
- `mem_read_data`  in  DATA_BITS: memory data, valid when `mem_read_ready` is high.

## Operation

- **Reset** (`reset_n`=0 at a clock edge):
  - state=IDLE, `rr_ptr`=0, `grant_id`=0.
  - All `consumer_read_ready`=0, all `consumer_read_data`=0.
  - `mem_read_valid`=0, `mem_read_address`=0.
- **State machine:** IDLE, READ_WAIT, RELEASE.
- **IDLE:**
  - Search consumers starting at `rr_ptr` in ascending order with wrap-around.
  - The first one with `consumer_read_valid` high wins: `grant_id` <= winner, `mem_read_address` <= its address, `mem_read_valid` <= 1, next state READ_WAIT.
  - With no requester, outputs are unchanged.
- **READ_WAIT:**
  - `mem_read_valid` is held high.
  - On `mem_read_ready`=1: `mem_read_valid` <= 0, `consumer_read_data[grant_id]` <= `mem_read_data`, `consumer_read_ready[grant_id]` <= 1, next state RELEASE.
- **RELEASE:**
  - `consumer_read_ready[grant_id]` <= 0 unconditionally, so ready is exactly one cycle wide.
  - Stay until `consumer_read_valid[grant_id]`=0 is sampled.
  - Then `rr_ptr` <= (`grant_id`+1) mod `NUM_CONSUMERS` and go to IDLE.
  - This prevents re-serving a fetch unit whose valid lingers after its ready pulse.
- **Widths:**
  - `grant_id` and `rr_ptr` are max(1, $clog2(NUM_CONSUMERS)) bits.
  - Wrap is an explicit compare to `NUM_CONSUMERS`-1, not a power-of-two overflow.
- **Boundary conditions:**
  - `mem_read_ready` sampled in IDLE or RELEASE is ignored; no output changes.
  - A consumer dropping valid during READ_WAIT: the response is still delivered and the pulse still issued. RELEASE then exits on its first cycle.
  - Simultaneous requests: the `rr_ptr` order decides. Non-granted requesters wait; their outputs are untouched.
  - Reset mid-transaction returns to the reset state at that edge. A later memory response is ignored (IDLE rule).
  - `NUM_CONSUMERS`=1: the pointer stays 0.

## Timing

- All outputs are registered; there is no combinational path from any input to any output.
- Consumer valid high from cycle C means:
  - `mem_read_valid` is visible from cycle C+1.
  - If memory returns ready in cycle C+1, consumer ready and data are visible in cycle C+2 (minimum latency 2).
- Memory latency adds one-for-one to consumer latency.
- RELEASE lasts at least one cycle. A fetch unit that drops valid one cycle after ready costs 2 RELEASE cycles.
- Best-case back-to-back throughput to different consumers is one grant per 4 cycles, with memory responding in the grant cycle.
- Starvation bound: a waiting consumer is granted within `NUM_CONSUMERS`-1 other transactions.

## Structure

- **Shared package `gpu_pkg`:** the `prog_arb_state_t` enum (IDLE, READ_WAIT, RELEASE; 2 bits) and the default width constants for program memory address and data.
- **Sub-module `rr_priority_picker`:** purely combinational.
  - Inputs: request vector and `rr_ptr`.
  - Outputs: `found` and `winner_id`.
  - The arbiter instantiates it once. It is reusable by a later data-memory arbiter.

## Test plan

- **Reset:** hold `reset_n`=0 for 2 cycles with all consumer valids high -> all ready=0, `mem_read_valid`=0, all data=0. After release, consumer 0 is granted first.
- **Single fetch:** consumer 2 requests address 0x1A; memory answers 0xBEEF one cycle after `mem_read_valid` -> `mem_read_address`=0x1A, `consumer_read_ready[2]` is a single pulse with data 0xBEEF at cycle C+2, and that data is held afterwards.
- **Round-robin:** all 4 consumers request continuously with distinct addresses -> grant order 0,1,2,3,0, each consumer's data matches its own address. No consumer is served twice while another waits.
- **Lingering valid:** a consumer keeps valid high 3 cycles after its ready pulse -> no second memory request for it, and RELEASE exits only after valid falls.
- **Spurious and late memory strobes:** pulse `mem_read_ready` in IDLE, and assert `reset_n`=0 during READ_WAIT followed by a memory response -> no consumer ready pulse, data unchanged, `mem_read_valid`=0.
- **Slow memory:** memory waits 5 cycles -> `mem_read_valid` and address stay stable throughout, and the ready pulse arrives the cycle after `mem_read_ready` is sampled.

Source files
------------

// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared types and default widths for the program-memory path
package gpu_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_WAIT = 2'd1,
        RELEASE   = 2'd2
    } prog_arb_state_t;

    localparam int PROG_ADDR_BITS = 8;
    localparam int PROG_DATA_BITS = 16;

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin search from a start pointer
module rr_priority_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_BITS-1:0] rr_ptr,
    output logic               found,
    output logic [ID_BITS-1:0] winner_id
);

    logic [ID_BITS:0]   idx_wide;
    logic [ID_BITS-1:0] idx;

    // Walk ascending from rr_ptr; the wrap subtracts NUM_REQ so non-power-of-two counts work.
    always_comb begin
        found     = 1'b0;
        winner_id = '0;
        idx_wide  = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_wide = {1'b0, rr_ptr} + (ID_BITS+1)'(k);
            if (idx_wide >= (ID_BITS+1)'(NUM_REQ)) begin
                idx_wide = idx_wide - (ID_BITS+1)'(NUM_REQ);
            end
            idx = idx_wide[ID_BITS-1:0];
            if (!found && req[idx]) begin
                found     = 1'b1;
                winner_id = idx;
            end
        end
    end

endmodule

// File: rtl/program_mem_arbiter.sv
// rtl/program_mem_arbiter.sv - round-robin arbiter sharing one program-memory read port
module program_mem_arbiter
    import gpu_pkg::*;
#(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS     = PROG_ADDR_BITS,
    parameter int DATA_BITS     = PROG_DATA_BITS
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
    output logic                                    mem_read_valid,
    output logic [ADDR_BITS-1:0]                    mem_read_address,
    input  logic                                    mem_read_ready,
    input  logic [DATA_BITS-1:0]                    mem_read_data
);

    localparam int ID_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    prog_arb_state_t    state;
    logic [ID_BITS-1:0] rr_ptr;
    logic [ID_BITS-1:0] grant_id;
    logic               found;
    logic [ID_BITS-1:0] winner_id;

    rr_priority_picker #(
        .NUM_REQ (NUM_CONSUMERS),
        .ID_BITS (ID_BITS)
    ) u_picker (
        .req       (consumer_read_valid),
        .rr_ptr    (rr_ptr),
        .found     (found),
        .winner_id (winner_id)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state               <= IDLE;
            rr_ptr              <= '0;
            grant_id            <= '0;
            consumer_read_ready <= '0;
            consumer_read_data  <= '0;
            mem_read_valid      <= 1'b0;
            mem_read_address    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_id         <= winner_id;
                        mem_read_address <= consumer_read_address[winner_id];
                        mem_read_valid   <= 1'b1;
                        state            <= READ_WAIT;
                    end
                end
                READ_WAIT: begin
                    if (mem_read_ready) begin
                        mem_read_valid                <= 1'b0;
                        consumer_read_data[grant_id]  <= mem_read_data;
                        consumer_read_ready[grant_id] <= 1'b1;
                        state                         <= RELEASE;
                    end
                end
                RELEASE: begin
                    consumer_read_ready[grant_id] <= 1'b0;
                    // Wait for the served unit to drop valid so a lingering request is not re-granted.
                    if (!consumer_read_valid[grant_id]) begin
                        rr_ptr <= (grant_id == ID_BITS'(NUM_CONSUMERS-1)) ? '0
                                                                          : grant_id + ID_BITS'(1);
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
